gift_dec_out_buf: RTL and testbench

Output-side buffer placed directly downstream of the pipelined GIFT-128 decryptor.
- Captures each 128-bit plaintext the decryptor presents with its one-cycle outValidData strobe.
- Stores blocks in a small FIFO, because the 40-stage pipeline cannot be stalled.
- Drains the FIFO as 32-bit words over a valid/ready stream to the system bus side.
- Reports fill level and a sticky overflow flag, so upstream logic can throttle key/data issue.

---
 rtl/gift_dec_out_buf_if.sv | 35 +++
 rtl/gift_dec_out_buf.sv | 105 ++++++++++
 tb/tb_gift_dec_out_buf.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/gift_dec_out_buf_if.sv
//------------------------------------------------------------------------------
// Module   : gift_dec_out_buf_if
// Brief    : Block-in / word-out stream and status bundle for gift_dec_out_buf.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface gift_dec_out_buf_if #(
  parameter int LVL_W = 3
);
  logic             inBlkValid;
  logic [127:0]     inBlkData;
  logic [31:0]      outWordData;
  logic             outWordValid;
  logic             inWordReady;
  logic             outWordLast;
  logic [LVL_W-1:0] outLevel;
  logic             outAlmostFull;
  logic             outOverflow;
  logic             inClrOvf;

  // Buffer side
  modport slave (
    input  inBlkValid, inBlkData, inWordReady, inClrOvf,
    output outWordData, outWordValid, outWordLast, outLevel, outAlmostFull, outOverflow
  );

  // Decryptor / consumer side
  modport master (
    output inBlkValid, inBlkData, inWordReady, inClrOvf,
    input  outWordData, outWordValid, outWordLast, outLevel, outAlmostFull, outOverflow
  );
endinterface

`default_nettype wire

// File: rtl/gift_dec_out_buf.sv
//------------------------------------------------------------------------------
// Module   : gift_dec_out_buf
// Brief    : 128-bit block FIFO after the GIFT-128 decryptor, drained as 32-bit words.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gift_dec_out_buf #(
  parameter int DEPTH    = 4,
  parameter int LVL_W    = 3,
  parameter int AFULL_TH = 2
) (
  input  wire logic          inClk,
  input  wire logic          inRstN,
  gift_dec_out_buf_if.slave  bus
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] C_DEPTH    = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] C_AFULL    = LVL_W'(AFULL_TH);
  localparam logic [LVL_W-1:0] C_LVL_ONE  = LVL_W'(1);
  localparam logic [1:0]       C_LAST_IDX = 2'd3;

  logic [127:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic [1:0]       r_idx;
  logic             r_ovf;

  logic         w_valid;
  logic         w_full;
  logic         w_xfer;
  logic         w_pop;
  logic         w_push;
  logic         w_drop;
  logic [127:0] w_head;
  logic [31:0]  w_word;

  assign w_valid = (r_level != '0);
  assign w_full  = (r_level == C_DEPTH);
  assign w_xfer  = w_valid & bus.inWordReady;
  assign w_pop   = w_xfer & (r_idx == C_LAST_IDX);
  // A pop on the same edge frees the slot, so a full FIFO still accepts the block.
  assign w_push  = bus.inBlkValid & (~w_full | w_pop);
  assign w_drop  = bus.inBlkValid & w_full & ~w_pop;
  assign w_head  = r_mem[r_rptr];

  always_comb begin
    w_word = 32'd0;
    case (r_idx)
      2'd0:    w_word = w_head[127:96];
      2'd1:    w_word = w_head[95:64];
      2'd2:    w_word = w_head[63:32];
      default: w_word = w_head[31:0];
    endcase
  end

  // Storage is unreset, so the word is forced to zero while nothing is held.
  assign bus.outWordData   = w_valid ? w_word : 32'd0;
  assign bus.outWordValid  = w_valid;
  assign bus.outWordLast   = w_valid & (r_idx == C_LAST_IDX);
  assign bus.outLevel      = r_level;
  assign bus.outAlmostFull = (r_level >= C_AFULL);
  assign bus.outOverflow   = r_ovf;

  always_ff @(posedge inClk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.inBlkData;
    end
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_idx   <= 2'd0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_xfer) begin
        r_idx <= r_idx + 2'd1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + C_LVL_ONE;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - C_LVL_ONE;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.inClrOvf) begin
        r_ovf <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gift_dec_out_buf.sv
//------------------------------------------------------------------------------
// Module   : tb_gift_dec_out_buf
// Brief    : Randomized and directed bench for gift_dec_out_buf against a queue model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gift_dec_out_buf;

  localparam int DEPTH    = 4;
  localparam int LVL_W    = 3;
  localparam int AFULL_TH = 2;

  logic clk;
  logic rst_n;

  gift_dec_out_buf_if #(.LVL_W(LVL_W)) bus ();

  gift_dec_out_buf #(
    .DEPTH    (DEPTH),
    .LVL_W    (LVL_W),
    .AFULL_TH (AFULL_TH)
  ) u_dut (
    .inClk  (clk),
    .inRstN (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of whole blocks, current word position, sticky flag.
  logic [127:0] m_q[$];
  int           m_idx = 0;
  logic         m_ovf = 1'b0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [127:0] exp_word;
    logic         has;
    has      = (m_q.size() > 0);
    exp_word = has ? ((m_q[0] >> (32 * (3 - m_idx))) & 128'hffff_ffff) : 128'd0;
    check_val("valid", 128'(bus.outWordValid), 128'(has));
    check_val("data",  128'(bus.outWordData),  exp_word);
    check_val("last",  128'(bus.outWordLast),  128'(has && m_idx == 3));
    check_val("level", 128'(bus.outLevel),     128'(m_q.size()));
    check_val("afull", 128'(bus.outAlmostFull), 128'(m_q.size() >= AFULL_TH));
    check_val("ovf",   128'(bus.outOverflow),  128'(m_ovf));
  endtask

  // One clock: drive inputs, compare outputs, take the edge, advance the model.
  task automatic step(input logic v, input logic [127:0] d, input logic rdy, input logic clr);
    bit xfer, pop, full;
    bus.inBlkValid  = v;
    bus.inBlkData   = d;
    bus.inWordReady = rdy;
    bus.inClrOvf    = clr;
    check_outputs();
    @(posedge clk);
    full = (m_q.size() == DEPTH);
    xfer = (m_q.size() > 0) && rdy;
    pop  = xfer && (m_idx == 3);
    if (xfer) m_idx++;
    if (pop) begin
      void'(m_q.pop_front());
      m_idx = 0;
    end
    if (v && (!full || pop)) m_q.push_back(d);
    if (v && full && !pop) m_ovf = 1'b1;
    else if (clr)          m_ovf = 1'b0;
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 128'd0, rdy, 1'b0);
  endtask

  initial begin
    bus.inBlkValid  = 1'b0;
    bus.inBlkData   = '0;
    bus.inWordReady = 1'b0;
    bus.inClrOvf    = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    idle(2, 1'b1);

    // Single block, full-rate drain
    step(1'b1, 128'h0123456789abcdef0011223344556677, 1'b1, 1'b0);
    idle(5, 1'b1);

    // Back-pressure after word 1
    step(1'b1, 128'h0123456789abcdef0011223344556677, 1'b0, 1'b0);
    step(1'b0, 128'd0, 1'b1, 1'b0);
    idle(5, 1'b0);
    idle(4, 1'b1);

    // Fill past full, drain, clear the flag
    for (int b = 1; b <= 5; b++) step(1'b1, 128'(b), 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(17, 1'b1);
    step(1'b0, 128'd0, 1'b0, 1'b1);
    idle(1, 1'b0);

    // Write on the same edge the head block's last word is accepted, at full
    for (int b = 6; b <= 9; b++) step(1'b1, 128'(b), 1'b0, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 128'haaaa, 1'b1, 1'b0);
    idle(1, 1'b0);
    idle(18, 1'b1);

    // All-zero plaintext as the decryptor yields for the key-0 known vector
    step(1'b1, 128'd0, 1'b1, 1'b0);
    idle(5, 1'b1);

    // Reset mid-run with two blocks held
    step(1'b1, 128'hbeef1, 1'b0, 1'b0);
    step(1'b1, 128'hbeef2, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    m_q.delete();
    m_idx = 0;
    m_ovf = 1'b0;
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic         v, r, c;
      logic [127:0] d;
      v = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 9) < ((i / 150) % 2 == 0 ? 7 : 3));
      c = ($urandom_range(0, 19) == 0);
      d = {$urandom, $urandom, $urandom, $urandom};
      step(v, d, r, c);
    end
    idle(30, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
